// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Also carries the bus address of the TX queue register.
package uart_sched_pkg;

    localparam int UART_FIFO_DEPTH  = 8;
    localparam int UART_ACK_TIMEOUT = 16;

    // Byte offset of the TX queue register in the UART window.
    localparam logic [11:0] UART_TXQ_ADDR = 12'h000;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } sched_state_e;

    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_fifo.sv
// Synchronous FIFO with occupancy count and flush.
// The head entry is read combinationally, so a pop has no bubble.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = din;
                wptr_d        = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: an entry is only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rptr_q];
    assign level = level_q;
    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Queues bus writes and feeds them one at a time to the UART sender
// over its enable/idle handshake; reports level, errors and drain.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int DEPTH       = UART_FIFO_DEPTH,
    parameter int ACK_TIMEOUT = UART_ACK_TIMEOUT
) (
    input  logic                   sysclk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    input  logic                   flush,
    input  logic                   clr_flags,
    input  logic                   tx_idle,
    output logic                   tx_en,
    output logic [7:0]             tx_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic                   busy,
    output logic                   drained,
    output logic                   overflow,
    output logic                   timeout
);

    localparam int CW = cnt_width(ACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(ACK_TIMEOUT);

    sched_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tx_en_q, tx_en_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          drained_q, drained_d;
    logic          overflow_q, overflow_d;
    logic          timeout_q, timeout_d;

    logic          pop;
    logic          push;
    logic          ovf_set;
    logic          tmo_set;
    logic [7:0]    head;
    logic          fifo_full;
    logic          fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (sysclk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (wr_data),
        .dout  (head),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        drained_d = 1'b0;
        pop       = 1'b0;
        tmo_set   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // flush wins over a launch in the same cycle
                if (!fifo_empty && tx_idle && !flush) begin
                    pop       = 1'b1;
                    tx_en_d   = 1'b1;
                    tx_data_d = head;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_idle) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_LIMIT) begin
                        tmo_set = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (tx_idle) begin
                    state_d   = IDLE;
                    // queue is empty after this cycle's push/flush
                    drained_d = flush || (fifo_empty && !wr_en);
                end
            end
        endcase

        push    = wr_en && !flush && (!fifo_full || pop);
        ovf_set = wr_en && !flush && fifo_full && !pop;

        overflow_d = ovf_set || (overflow_q && !clr_flags);
        timeout_d  = tmo_set || (timeout_q && !clr_flags);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= 8'h00;
            drained_q  <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_en_q    <= tx_en_d;
            tx_data_q  <= tx_data_d;
            drained_q  <= drained_d;
            overflow_q <= overflow_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_en    = tx_en_q;
    assign tx_data  = tx_data_q;
    assign drained  = drained_q;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: queue-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_scheduler;
    import uart_sched_pkg::*;

    localparam int DEPTH = UART_FIFO_DEPTH;
    localparam int ACK   = UART_ACK_TIMEOUT;

    logic       sysclk    = 1'b0;
    logic       reset     = 1'b1;
    logic       wr_en     = 1'b0;
    logic [7:0] wr_data   = 8'h00;
    logic       flush     = 1'b0;
    logic       clr_flags = 1'b0;
    logic       tx_idle   = 1'b1;
    logic       tx_en;
    logic [7:0] tx_data;
    logic [3:0] level;
    logic       full, empty, busy, drained, overflow, timeout;

    int  nvec = 0;
    int  nmis = 0;
    bit  chk_en = 1'b0;

    // sender behaviour: 0 = normal, 1 = ignores launches, 2 = stuck busy
    int  snd_mode = 0;
    int  snd_len  = 3;
    int  hold     = 0;

    logic [7:0] launched[$];

    // reference model: byte queue plus the one byte owned by the sender
    logic [7:0] m_q[$];
    bit         m_inflight = 1'b0;
    bit         m_acked    = 1'b0;
    int         m_age      = 0;
    bit         m_tx_en    = 1'b0;
    logic [7:0] m_tx_data  = 8'h00;
    bit         m_drained  = 1'b0;
    bit         m_ovf      = 1'b0;
    bit         m_tmo      = 1'b0;

    uart_tx_scheduler #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .clr_flags (clr_flags),
        .tx_idle   (tx_idle),
        .tx_en     (tx_en),
        .tx_data   (tx_data),
        .level     (level),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .drained   (drained),
        .overflow  (overflow),
        .timeout   (timeout)
    );

    initial forever #5 sysclk = ~sysclk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h want %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int pre;
        bit popped;
        bit done;
        bit ovf_set;
        bit tmo_set;
        if (reset) begin
            m_q.delete();
            m_inflight = 0; m_acked = 0; m_age = 0;
            m_tx_en = 0; m_tx_data = 8'h00; m_drained = 0;
            m_ovf = 0; m_tmo = 0;
            return;
        end
        pre = m_q.size();
        popped = 0; done = 0; ovf_set = 0; tmo_set = 0;
        m_tx_en = 0;
        m_drained = 0;
        if (!m_inflight) begin
            if (pre > 0 && tx_idle && !flush) begin
                m_tx_data  = m_q.pop_front();
                popped     = 1;
                m_tx_en    = 1;
                m_inflight = 1;
                m_acked    = 0;
                m_age      = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (!m_acked) begin
            if (!tx_idle) m_acked = 1;
            else if (m_age == ACK) begin
                tmo_set = 1;
                m_inflight = 0;
            end else m_age++;
        end else if (tx_idle) begin
            m_inflight = 0;
            done = 1;
        end
        if (flush) m_q.delete();
        else if (wr_en) begin
            if (pre < DEPTH || popped) m_q.push_back(wr_data);
            else ovf_set = 1;
        end
        if (done) m_drained = (m_q.size() == 0);
        m_ovf = ovf_set || (m_ovf && !clr_flags);
        m_tmo = tmo_set || (m_tmo && !clr_flags);
    endtask

    initial forever begin
        @(posedge sysclk);
        model_step();
    end

    initial forever begin
        @(negedge sysclk);
        if (chk_en) begin
            chk("m_level", 32'(level), 32'(m_q.size()));
            chk("m_full", 32'(full), 32'(m_q.size() == DEPTH));
            chk("m_empty", 32'(empty), 32'(m_q.size() == 0));
            chk("m_busy", 32'(busy), 32'(m_inflight));
            chk("m_tx_en", 32'(tx_en), 32'(m_tx_en));
            chk("m_tx_data", 32'(tx_data), 32'(m_tx_data));
            chk("m_drained", 32'(drained), 32'(m_drained));
            chk("m_overflow", 32'(overflow), 32'(m_ovf));
            chk("m_timeout", 32'(timeout), 32'(m_tmo));
        end
    end

    // sender model reacts just after the falling edge
    initial forever begin
        @(negedge sysclk);
        #1;
        if (snd_mode == 2) tx_idle = 1'b0;
        else if (snd_mode == 1) tx_idle = 1'b1;
        else begin
            if (tx_en === 1'b1) hold = snd_len;
            if (hold > 0) begin
                tx_idle = 1'b0;
                hold--;
            end else tx_idle = 1'b1;
        end
    end

    initial forever begin
        @(negedge sysclk);
        if (tx_en === 1'b1) launched.push_back(tx_data);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got running want finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check_reset(input string tag);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_empty"}, 32'(empty), 1);
        chk({tag, "_full"}, 32'(full), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_tx_en"}, 32'(tx_en), 0);
        chk({tag, "_tx_data"}, 32'(tx_data), 0);
        chk({tag, "_drained"}, 32'(drained), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    task automatic wait_drained(input int max, input string tag);
        int k = 0;
        while (drained !== 1'b1 && k < max) begin
            @(negedge sysclk);
            k++;
        end
        chk({tag, "_drained_seen"}, 32'(drained), 1);
    endtask

    initial begin
        int dcnt;
        int tcnt;
        int k;

        repeat (3) @(negedge sysclk);
        chk_en = 1'b1;
        check_reset("rst");

        // single byte
        reset = 1'b0; snd_mode = 0; snd_len = 20;
        wr_en = 1'b1; wr_data = 8'hA5;
        @(negedge sysclk);
        wr_en = 1'b0;
        chk("sb_level_c1", 32'(level), 1);
        @(negedge sysclk);
        chk("sb_tx_en_c2", 32'(tx_en), 1);
        chk("sb_tx_data_c2", 32'(tx_data), 'hA5);
        chk("sb_level_c2", 32'(level), 0);
        dcnt = 0;
        repeat (30) begin
            @(negedge sysclk);
            if (drained === 1'b1) dcnt++;
        end
        chk("sb_drained_once", 32'(dcnt), 1);

        // burst fill against a busy sender
        snd_mode = 2;
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            @(negedge sysclk);
        end
        wr_en = 1'b0;
        chk("burst_level", 32'(level), 8);
        chk("burst_full", 32'(full), 1);
        chk("burst_ovf", 32'(overflow), 1);
        launched.delete();
        snd_mode = 0; snd_len = 3;
        wait_drained(300, "burst");
        chk("burst_count", 32'(launched.size()), 8);
        for (int i = 0; i < 8; i++)
            if (i < launched.size())
                chk("burst_order", 32'(launched[i]), 32'(i));
        chk("burst_ovf_sticky", 32'(overflow), 1);
        clr_flags = 1'b1;
        @(negedge sysclk);
        clr_flags = 1'b0;
        chk("burst_ovf_clr", 32'(overflow), 0);
        repeat (3) @(negedge sysclk);

        // push and pop together while full
        snd_mode = 2;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            @(negedge sysclk);
        end
        wr_en = 1'b0;
        chk("bnd_pre_level", 32'(level), 8);
        snd_mode = 0; snd_len = 4;
        wr_en = 1'b1; wr_data = 8'h48;
        @(negedge sysclk);
        wr_en = 1'b0;
        chk("bnd_level_full", 32'(level), 8);
        chk("bnd_no_ovf", 32'(overflow), 0);
        chk("bnd_tx_en", 32'(tx_en), 1);
        chk("bnd_tx_data", 32'(tx_data), 'h40);

        // push and flush together
        wr_en = 1'b1; wr_data = 8'h99; flush = 1'b1;
        @(negedge sysclk);
        wr_en = 1'b0; flush = 1'b0;
        chk("pf_level", 32'(level), 0);
        chk("pf_empty", 32'(empty), 1);
        chk("pf_no_ovf", 32'(overflow), 0);
        chk("pf_busy", 32'(busy), 1);
        wait_drained(50, "pf");
        repeat (3) @(negedge sysclk);

        // sender never acknowledges
        snd_mode = 1;
        wr_en = 1'b1; wr_data = 8'h11;
        @(negedge sysclk);
        wr_data = 8'h22;
        @(negedge sysclk);
        wr_en = 1'b0;
        chk("to_tx_en", 32'(tx_en), 1);
        chk("to_tx_data", 32'(tx_data), 'h11);
        k = 0;
        while (timeout !== 1'b1 && k < 40) begin
            @(negedge sysclk);
            k++;
        end
        chk("to_latency", 32'(k), 17);
        @(negedge sysclk);
        chk("to_next_tx_en", 32'(tx_en), 1);
        chk("to_next_tx_data", 32'(tx_data), 'h22);
        repeat (20) @(negedge sysclk);
        chk("to_sticky", 32'(timeout), 1);
        clr_flags = 1'b1;
        @(negedge sysclk);
        clr_flags = 1'b0;
        chk("to_clr", 32'(timeout), 0);
        chk("to_idle", 32'(busy), 0);

        // flush while byte 0 is on the wire
        snd_mode = 0; snd_len = 10;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h31 + i);
            @(negedge sysclk);
        end
        wr_en = 1'b0;
        chk("fl_busy", 32'(busy), 1);
        chk("fl_level", 32'(level), 3);
        flush = 1'b1;
        @(negedge sysclk);
        flush = 1'b0;
        chk("fl_level_after", 32'(level), 0);
        dcnt = 0; tcnt = 0;
        repeat (20) begin
            @(negedge sysclk);
            if (drained === 1'b1) dcnt++;
            if (tx_en === 1'b1) tcnt++;
        end
        chk("fl_drained_once", 32'(dcnt), 1);
        chk("fl_no_launch", 32'(tcnt), 0);

        // reset while in LAUNCH
        snd_len = 5;
        wr_en = 1'b1; wr_data = 8'h5A;
        @(negedge sysclk);
        wr_en = 1'b0;
        @(negedge sysclk);
        chk("rl_tx_en", 32'(tx_en), 1);
        reset = 1'b1;
        @(negedge sysclk);
        check_reset("rl");
        reset = 1'b0;
        repeat (10) @(negedge sysclk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
